input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Parametrised multi-channel front end for asynchronous inputs (buttons,
//   switches, remote UART control lines). Each channel has an N-stage
//   synchroniser, a counter-based debounce filter and rise/fall one-cycle tick
//   generation. Sits between the board pins and the UART TX/RX control FSMs.
//   Replaces the per-signal sync/debounce/edge-detect chains with one block.
// PARAMETERS
//   CHANNELS        4  number of independent input channels (>=1)
//   SYNC_STAGES     2  synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES 4  consecutive differing samples needed to accept a new level (>=1)
// PORTS
//   clk        in   1         system clock; all flops on posedge
//   rst        in   1         asynchronous, active-high reset
//   sig_in     in   CHANNELS  raw asynchronous inputs, bit i = channel i
//   level_out  out  CHANNELS  debounced, synchronised level per channel
//   rise_tick  out  CHANNELS  1-cycle pulse when level_out[i] goes 0->1
//   fall_tick  out  CHANNELS  1-cycle pulse when level_out[i] goes 1->0
//   any_rise   out  1         OR of rise_tick (registered ticks, combinational OR)
// BEHAVIOUR
//   Reset (rst=1, async): all sync flops, counters, level_out, rise_tick,
//     fall_tick = 0; any_rise = 0. Reset mid-operation discards in-flight counts.
//   Channels are fully independent; identical logic per bit.
//   Sync: s[0] <= sig_in[i]; s[k] <= s[k-1]; sync_out = s[SYNC_STAGES-1].
//   Debounce: counter cnt, width $clog2(DEBOUNCE_CYCLES+1), min 1 bit.
//     sync_out == level_out[i]           : cnt <= 0.
//     differ and cnt <  DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//     differ and cnt == DEBOUNCE_CYCLES-1: level_out[i] <= sync_out; cnt <= 0.
//     Any sample equal to level_out restarts the count (glitch rejection).
//     DEBOUNCE_CYCLES=1: no filtering, level follows sync_out next edge.
//   Ticks (registered, same edge as level update):
//     rise_tick[i] <= update & sync_out; fall_tick[i] <= update & ~sync_out;
//     otherwise 0. Each tick high exactly one cycle, concurrent with the first
//     cycle of the new level_out value. rise and fall never both high.
//   Latency: sig_in stable change sampled at edge 1 -> level_out/tick change
//     after edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: 6 edges).
//   Minimum accepted pulse width: DEBOUNCE_CYCLES clk periods; shorter ones
//     produce no level change and no tick.
//   Input held high through reset release: level_out rises after full latency
//     and rise_tick fires once (reset level is 0 by definition).
//   Counter never wraps: it is cleared on update or match, max DEBOUNCE_CYCLES-1.
// TESTING
//   T1 defaults, sig_in[0] 0->1 held: level_out[0]=1 and rise_tick[0]=1 after
//      edge 6 (1-cycle pulse), any_rise=1 same cycle; other channels stay 0.
//   T2 3-cycle high glitch on ch1 (DEBOUNCE_CYCLES=4): level_out[1] stays 0,
//      no ticks; bouncy 1,0,1,1,1,1 settles -> single rise_tick 4 cycles after
//      last 0 leaves sync chain.
//   T3 ch2 high then low after 20 cycles: one rise_tick, one fall_tick, each
//      exactly 1 cycle, separated by 20 cycles.
//   T4 all 4 channels toggled on same edge: rise_tick=4'b1111 for one cycle,
//      level_out=4'b1111.
//   T5 rst asserted async mid-count (cnt=2): outputs 0 immediately, no tick;
//      input held high at release -> rise_tick after 6 edges.
//   T6 CHANNELS=1, SYNC_STAGES=3, DEBOUNCE_CYCLES=1: level follows sig_in with
//      4-edge latency, every stable toggle yields a tick.

Source files
------------

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel front end for asynchronous board inputs (buttons, switches,
// remote UART control lines). Every channel has the same three pieces:
//   1. an SYNC_STAGES-deep synchroniser chain,
//   2. a counter-based debounce filter that accepts a new level only after
//      DEBOUNCE_CYCLES consecutive synchronised samples differ from the
//      current level,
//   3. registered one-cycle rise/fall ticks that line up with the first
//      cycle of the new debounced level.
//
// Ports
//   clk        system clock, all flops on the rising edge
//   rst        asynchronous, active-high reset
//   sig_in     raw asynchronous inputs, bit i = channel i
//   level_out  debounced, synchronised level per channel
//   rise_tick  one-cycle pulse when level_out[i] goes 0->1
//   fall_tick  one-cycle pulse when level_out[i] goes 1->0
//   any_rise   OR of all rise_tick bits
// ---------------------------------------------------------------------------
module input_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_tick,
    output logic [CHANNELS-1:0] fall_tick,
    output logic                any_rise
);

    // The counter only ever reaches DEBOUNCE_CYCLES-1 before being cleared,
    // so this width is always sufficient and never wraps.
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt;
        logic                   level_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   sync_out;
        logic                   differ;
        logic                   update;

        assign sync_out = sync_q[SYNC_STAGES-1];
        assign differ   = sync_out ^ level_q;
        // The new level is accepted on the sample that completes the run of
        // DEBOUNCE_CYCLES differing samples.
        assign update   = differ && (cnt == CNT_LAST);

        // Synchroniser chain: bit 0 captures the pin, the top bit feeds the filter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
            end
        end

        // Debounce counter, accepted level and edge ticks. Any sample equal to
        // the current level restarts the count, which rejects short glitches.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= update & sync_out;
                fall_q <= update & ~sync_out;
                if (!differ || update) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (update) begin
                    level_q <= sync_out;
                end
            end
        end

        assign level_out[i] = level_q;
        assign rise_tick[i] = rise_q;
        assign fall_tick[i] = fall_q;
    end

    assign any_rise = |rise_tick;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//
// Drives a default-parameter input_conditioner (4 channels, 2 sync stages,
// debounce 4) and a single-channel instance with 3 sync stages and no
// filtering. Expected values come from a directed table, hand-written
// corner-case sequences, and a sliding-window reference model: a level flips
// once the last DEBOUNCE_CYCLES synchronised samples all disagree with it.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int CH    = 4;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int HLEN  = SYNC + DEB;
    localparam int SYNC6 = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] sig_in = '0;
    logic [CH-1:0] level_out, rise_tick, fall_tick;
    logic          any_rise;

    logic          sig6 = 1'b0;
    logic          level6, rise6, fall6, any6;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw samples per edge, newest at index 0.
    logic [CH-1:0] hist [HLEN];
    logic [CH-1:0] m_level, m_rise, m_fall;
    logic          hist6 [SYNC6+2];

    typedef struct {
        logic [CH-1:0] sig;
        logic [CH-1:0] level;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } vec_t;

    vec_t tbl [16];

    input_conditioner #(.CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .level_out(level_out),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .any_rise (any_rise)
    );

    input_conditioner #(.CHANNELS(1), .SYNC_STAGES(SYNC6), .DEBOUNCE_CYCLES(1)) u_dut6 (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig6),
        .level_out(level6),
        .rise_tick(rise6),
        .fall_tick(fall6),
        .any_rise (any6)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < HLEN; k++) hist[k] = '0;
        for (int k = 0; k < SYNC6 + 2; k++) hist6[k] = 1'b0;
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic modelStep();
        logic ones, zeros, upd;
        for (int k = HLEN - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = sig_in;
        for (int ch = 0; ch < CH; ch++) begin
            ones  = 1'b1;
            zeros = 1'b1;
            for (int k = SYNC; k < SYNC + DEB; k++) begin
                ones  = ones & hist[k][ch];
                zeros = zeros & ~hist[k][ch];
            end
            upd = m_level[ch] ? zeros : ones;
            m_rise[ch]  = upd & ~m_level[ch];
            m_fall[ch]  = upd & m_level[ch];
            m_level[ch] = m_level[ch] ^ upd;
        end
        for (int k = SYNC6 + 1; k > 0; k--) hist6[k] = hist6[k-1];
        hist6[0] = sig6;
    endtask

    // Called at a falling edge: set inputs, step the model, wait one clock.
    task automatic applyStimulus(input logic [CH-1:0] s, input logic s6);
        sig_in = s;
        sig6   = s6;
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkAgainstModel();
        checkOutput("rand_level", level_out, m_level);
        checkOutput("rand_rise",  rise_tick, m_rise);
        checkOutput("rand_fall",  fall_tick, m_fall);
        checkOutput("rand_any",   any_rise,  |m_rise);
        checkOutput("ch6_level",  level6, hist6[SYNC6]);
        checkOutput("ch6_rise",   rise6,  hist6[SYNC6] & ~hist6[SYNC6+1]);
        checkOutput("ch6_fall",   fall6,  ~hist6[SYNC6] & hist6[SYNC6+1]);
    endtask

    initial begin
        int rise_n, fall_n, rise_t, fall_t;
        logic [CH-1:0] rs;
        int hold [CH];
        int hold6;
        logic bouncy [12];

        // Table: ch0 held high for 8 edges then low; level follows 6 edges later.
        for (int i = 0; i < 16; i++) begin
            tbl[i].sig   = (i < 8) ? 4'b0001 : 4'b0000;
            tbl[i].level = (i >= 5 && i < 13) ? 4'b0001 : 4'b0000;
            tbl[i].rise  = (i == 5) ? 4'b0001 : 4'b0000;
            tbl[i].fall  = (i == 13) ? 4'b0001 : 4'b0000;
        end
        bouncy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_level", level_out, 0);
        checkOutput("reset_rise",  rise_tick, 0);
        checkOutput("reset_fall",  fall_tick, 0);
        checkOutput("reset_any",   any_rise,  0);
        checkOutput("reset_lvl6",  level6,    0);
        rst = 1'b0;

        $display("[TB] T1 table-driven single channel");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].sig, 1'b0);
            checkOutput("t1_level", level_out, tbl[i].level);
            checkOutput("t1_rise",  rise_tick, tbl[i].rise);
            checkOutput("t1_fall",  fall_tick, tbl[i].fall);
            checkOutput("t1_any",   any_rise,  |tbl[i].rise);
        end

        $display("[TB] T2 glitch rejection and bouncy settle on ch1");
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k < 3) ? 4'b0010 : 4'b0000, 1'b0);
            checkOutput("t2_glitch_level", level_out[1], 0);
            checkOutput("t2_glitch_ticks", {rise_tick[1], fall_tick[1]}, 0);
        end
        for (int k = 0; k < 12; k++) begin
            applyStimulus({2'b00, bouncy[k], 1'b0}, 1'b0);
            checkOutput("t2_bounce_rise",  rise_tick[1], (k == 7) ? 1 : 0);
            checkOutput("t2_bounce_level", level_out[1], (k >= 7) ? 1 : 0);
        end
        repeat (8) applyStimulus(4'b0000, 1'b0);
        checkOutput("t2_return_level", level_out, 0);

        $display("[TB] T3 ch2 pulse of 20 cycles");
        rise_n = 0; fall_n = 0; rise_t = 0; fall_t = 0;
        for (int k = 0; k < 50; k++) begin
            applyStimulus((k < 20) ? 4'b0100 : 4'b0000, 1'b0);
            if (rise_tick[2]) begin rise_n++; rise_t = k; end
            if (fall_tick[2]) begin fall_n++; fall_t = k; end
        end
        checkOutput("t3_rise_count", rise_n, 1);
        checkOutput("t3_fall_count", fall_n, 1);
        checkOutput("t3_rise_edge",  rise_t, 5);
        checkOutput("t3_separation", fall_t - rise_t, 20);

        $display("[TB] T4 all channels together");
        for (int k = 0; k < 7; k++) begin
            applyStimulus(4'b1111, 1'b0);
            checkOutput("t4_level", level_out, (k >= 5) ? 4'b1111 : 4'b0000);
            checkOutput("t4_rise",  rise_tick, (k == 5) ? 4'b1111 : 4'b0000);
            checkOutput("t4_any",   any_rise,  (k == 5) ? 1 : 0);
        end

        $display("[TB] T5 asynchronous reset mid-count");
        repeat (4) applyStimulus(4'b0000, 1'b0);
        checkOutput("t5_pre_level", level_out, 4'b1111);
        #2;
        sig_in = 4'b1111;
        rst    = 1'b1;
        #1;
        modelReset();
        checkOutput("t5_async_level", level_out, 0);
        checkOutput("t5_async_ticks", {rise_tick, fall_tick}, 0);
        checkOutput("t5_async_any",   any_rise, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(4'b1111, 1'b0);
            checkOutput("t5_level", level_out, (k >= 5) ? 4'b1111 : 4'b0000);
            checkOutput("t5_rise",  rise_tick, (k == 5) ? 4'b1111 : 4'b0000);
            checkOutput("t5_fall",  fall_tick, 0);
        end

        $display("[TB] T6 and random stimulus against reference model");
        rs = sig_in;
        for (int c = 0; c < CH; c++) hold[c] = 0;
        hold6 = 0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    rs[c]   = ($urandom_range(0, 1) == 1) ? ~rs[c] : rs[c];
                    hold[c] = $urandom_range(1, 7);
                end
                hold[c]--;
            end
            if (hold6 == 0) begin
                sig6  = ~sig6;
                hold6 = $urandom_range(1, 4);
            end
            hold6--;
            applyStimulus(rs, sig6);
            checkAgainstModel();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
